// File: rtl/memc_pkg.sv
// Shared types and constants for the MEMC frame sequencer and its datapath users.
package memc_pkg;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int FRAME_W   = 64;
    localparam int BLK       = 8;
    localparam int NBLK      = 64;
    localparam int ADDR_W    = 12;
    localparam int BLK_IDX_W = 6;

    localparam int MV_DX_W = 4;
    localparam int MV_DY_W = 4;
    localparam int MV_W    = MV_DY_W + MV_DX_W;

    typedef struct packed {
        logic signed [MV_DY_W-1:0] dy;
        logic signed [MV_DX_W-1:0] dx;
    } mv_t;

    // Block-ordered counters map to raster y*64+x by interleaving block and in-block fields.
    function automatic logic [ADDR_W-1:0] raster_addr(input logic [5:0] blk,
                                                      input logic [2:0] row,
                                                      input logic [2:0] col);
        return {blk[5:3], row, blk[2:0], col};
    endfunction

endpackage

// File: rtl/memc_sched_if.sv
// Pixel, frame-buffer, search-engine and motion-vector signals of the MEMC sequencer.
interface memc_sched_if;
    import memc_pkg::*;

    logic                 pixel_valid;
    logic [7:0]           pixel;
    logic                 busy;
    logic                 fb_we;
    logic                 fb_bank;
    logic [ADDR_W-1:0]    fb_addr;
    logic [7:0]           fb_wdata;
    logic                 job_valid;
    logic                 job_ready;
    logic [BLK_IDX_W-1:0] job_blk;
    logic                 job_cur_bank;
    logic                 res_valid;
    logic [MV_W-1:0]      res_mv;
    logic                 mv_valid;
    logic [MV_W-1:0]      mv;
    logic [BLK_IDX_W-1:0] mv_addr;
    logic                 err;

    modport master (
        input  pixel_valid, pixel, job_ready, res_valid, res_mv,
        output busy, fb_we, fb_bank, fb_addr, fb_wdata,
               job_valid, job_blk, job_cur_bank,
               mv_valid, mv, mv_addr, err
    );

    modport slave (
        output pixel_valid, pixel, job_ready, res_valid, res_mv,
        input  busy, fb_we, fb_bank, fb_addr, fb_wdata,
               job_valid, job_blk, job_cur_bank,
               mv_valid, mv, mv_addr, err
    );

endinterface

// File: rtl/memc_pix_cnt.sv
// Block-ordered pixel position counters (col, row within block, block index) with wrap flags.
module memc_pix_cnt (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [2:0] col,
    output logic [2:0] row,
    output logic [5:0] blk,
    output logic       col_wrap,
    output logic       row_wrap,
    output logic       blk_wrap
);

    assign col_wrap = (col == 3'd7);
    assign row_wrap = (row == 3'd7);
    assign blk_wrap = (blk == 6'd63);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
            blk <= '0;
        end else if (en) begin
            col <= col + 3'd1;
            if (col_wrap) begin
                row <= row + 3'd1;
                if (row_wrap) begin
                    blk <= blk + 6'd1;
                end
            end
        end
    end

endmodule

// File: rtl/memc_sched.sv
// MEMC frame sequencer: loads ping-pong frame banks, issues 64 block-match jobs per frame pair,
// and forwards returned motion vectors.
module memc_sched
    import memc_pkg::*;
#(
    parameter int NUM_FRAMES = 10,
    parameter int MAX_OUT    = 2
) (
    input  logic          clk,
    input  logic          rst,
    memc_sched_if.master  bus
);

    localparam logic [1:0] S_LOAD   = ST_LOAD;
    localparam logic [1:0] S_SEARCH = ST_SEARCH;
    localparam logic [1:0] S_DONE   = ST_DONE;

    localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAMES);
    localparam logic [2:0] OUT_LIMIT  = 3'(MAX_OUT);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic       busy_q;
    logic [3:0] frame_cnt;
    logic       bank;
    logic       cur_bank;
    logic [6:0] job_cnt;
    logic [2:0] outstanding;
    logic [5:0] res_idx;
    logic       mv_valid_q;
    mv_t        mv_q;
    logic [5:0] mv_addr_q;
    logic       err_q;

    logic [2:0] col;
    logic [2:0] row;
    logic [5:0] blk;
    logic       col_wrap;
    logic       row_wrap;
    logic       blk_wrap;

    logic       accept;
    logic       frame_end;
    logic       job_valid;
    logic       job_acc;
    logic       res_ok;
    logic       last_res;

    assign accept    = bus.pixel_valid && !busy_q;
    assign frame_end = accept && col_wrap && row_wrap && blk_wrap;

    memc_pix_cnt u_pix_cnt (
        .clk      (clk),
        .rst      (rst),
        .en       (accept),
        .col      (col),
        .row      (row),
        .blk      (blk),
        .col_wrap (col_wrap),
        .row_wrap (row_wrap),
        .blk_wrap (blk_wrap)
    );

    // job_valid comes only from registers so the engine may gate job_ready on it freely.
    assign job_valid = (state == S_SEARCH) && !job_cnt[6] && (outstanding < OUT_LIMIT);
    assign job_acc   = job_valid && bus.job_ready;
    assign res_ok    = bus.res_valid && (outstanding != 3'd0);
    assign last_res  = res_ok && (res_idx == 6'd63);

    // NOTE: combinational blocks assign a default first so no path leaves a latch behind.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (frame_end && (frame_cnt != 4'd0)) begin
                    state_nxt = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (last_res) begin
                    state_nxt = (frame_cnt == LAST_FRAME) ? S_DONE : S_LOAD;
                end
            end
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_LOAD;
            busy_q    <= 1'b0;
            frame_cnt <= '0;
            bank      <= 1'b0;
            cur_bank  <= 1'b0;
        end else begin
            state  <= state_nxt;
            busy_q <= (state_nxt != S_LOAD);
            if (frame_end) begin
                frame_cnt <= frame_cnt + 4'd1;
                if (frame_cnt == 4'd0) begin
                    bank <= ~bank;
                end else begin
                    cur_bank <= bank;
                end
            end
            // The frame just searched as current stays; the old reference bank is overwritten next.
            if (last_res && (frame_cnt != LAST_FRAME)) begin
                bank <= ~bank;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_cnt     <= '0;
            outstanding <= '0;
            res_idx     <= '0;
        end else begin
            if (last_res) begin
                job_cnt <= '0;
            end else if (job_acc) begin
                job_cnt <= job_cnt + 7'd1;
            end
            case ({job_acc, res_ok})
                2'b10:   outstanding <= outstanding + 3'd1;
                2'b01:   outstanding <= outstanding - 3'd1;
                default: outstanding <= outstanding;
            endcase
            if (res_ok) begin
                res_idx <= res_idx + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mv_valid_q <= 1'b0;
            mv_q       <= '0;
            mv_addr_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            mv_valid_q <= res_ok;
            if (res_ok) begin
                mv_q      <= mv_t'(bus.res_mv);
                mv_addr_q <= res_idx;
            end
            if ((bus.res_valid && (outstanding == 3'd0)) || (bus.pixel_valid && busy_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.busy         = busy_q;
    assign bus.fb_we        = accept;
    assign bus.fb_bank      = bank;
    assign bus.fb_addr      = raster_addr(blk, row, col);
    assign bus.fb_wdata     = accept ? bus.pixel : 8'h00;
    assign bus.job_valid    = job_valid;
    assign bus.job_blk      = job_cnt[5:0];
    assign bus.job_cur_bank = cur_bank;
    assign bus.mv_valid     = mv_valid_q;
    assign bus.mv           = mv_q;
    assign bus.mv_addr      = mv_addr_q;
    assign bus.err          = err_q;

endmodule

// File: doc/memc_sched.md
# memc_sched

Frame-level sequencer for the motion-estimation/compensation (MEMC) datapath. It accepts the 8×8-block-ordered pixel stream, writes each 64×64 frame into one of two ping-pong frame-buffer banks, and throttles the source with `busy`. Once a current/reference frame pair is resident, it issues 64 block-match jobs to the search engine and forwards the returned motion vectors as `mv`/`mv_addr`. It sits between the pixel input port and the frame buffers plus search engine.

## Interface
- `NUM_FRAMES`, 10: frames in one sequence; range 2..15.
- `MAX_OUT`, 2: maximum search jobs in flight; range 1..4.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pixel_valid` in 1: pixel present this cycle.
- `pixel` in 8: luma sample.
- `busy` out 1: when 1, `pixel_valid` is ignored.
- `fb_we` out 1: frame-buffer write strobe.
- `fb_bank` out 1: bank being written.
- `fb_addr` out 12: raster address, y*64+x.
- `fb_wdata` out 8: pixel data.
- `job_valid` out 1: search job offered.
- `job_ready` in 1: engine accepts job.
- `job_blk` out 6: block index, {blk_row, blk_col}.
- `job_cur_bank` out 1: bank holding the current frame; the reference frame is the other bank.
- `res_valid` in 1: one-cycle result pulse; results arrive in job order.
- `res_mv` in 8: {dy[3:0], dx[3:0]}, two's complement.
- `mv_valid` out 1: motion vector output.
- `mv` out 8: registered copy of `res_mv`.
- `mv_addr` out 6: block index of `mv`.
- `err` out 1: sticky protocol error.

## Operation
- States: LOAD, SEARCH, DONE.
- Reset values: state=LOAD, frame count=0, all outputs 0, `fb_bank`=0.
- Pixel order: 64 pixels row-major within a block, then blocks in raster order (8 blocks per block-row, 64 blocks per frame).
- Counters:
  - col[2:0]: increments every accepted pixel.
  - row[2:0]: increments when col wraps.
  - blk[5:0]: increments when row wraps.
  - `fb_addr` = {blk[5:3], row, blk[2:0], col}.
- LOAD:
  - Each accepted pixel (`pixel_valid`=1 and `busy`=0) drives `fb_we`/`fb_addr`/`fb_wdata`/`fb_bank` in the same cycle (combinational from the counters).
  - At the 4096th pixel, the frame count increments.
  - Frame 1 complete: `fb_bank` toggles and the block stays in LOAD.
  - Frame k≥2 complete: go to SEARCH with `job_cur_bank`=`fb_bank` of frame k.
- SEARCH:
  - Jobs are issued for blk 0..63 in order.
  - `job_valid` is held with a stable `job_blk` until `job_ready`=1.
  - A new job is offered only while outstanding < `MAX_OUT`.
  - The outstanding counter increments on an accepted job and decrements on `res_valid`; both in one cycle leave it unchanged.
  - Each `res_valid` produces `mv_valid`=1, `mv`=`res_mv`, `mv_addr`=result index (0..63, separate counter) one cycle later.
  - After the 64th result:
    - if frame count = `NUM_FRAMES`, go to DONE;
    - otherwise toggle `fb_bank` (the write bank becomes the old reference bank) and go to LOAD.
- DONE: `busy`=1 and no jobs issued until reset.
- `busy` = (state≠LOAD), registered from state.
- `err` sets (sticky until reset) on either of:
  - `res_valid` with outstanding=0;
  - `pixel_valid` while `busy`=1.
- Neither error changes state or counters. Dropped pixels are not written.
- `rst` mid-operation: immediate return to reset values; in-flight results are discarded.

## Timing
- Last pixel of frame k≥2 accepted at cycle t: `busy`=1 at t+1; `job_valid` may rise at t+1.
- Pixel-to-`fb_we` latency: 0 cycles. `res_valid` to `mv_valid` latency: 1 cycle.
- 64th `res_valid` at cycle t: state=LOAD and `busy`=0 at t+1; the last `mv_valid` is also at t+1.
- Maximum throughput: one job per cycle when `job_ready` is high and the in-flight limit is not reached.
- `job_valid` does not depend combinationally on `job_ready`.

## Structure
- Shared package `memc_pkg`:
  - state enum;
  - FRAME_W=64, BLK=8, NBLK=64;
  - mv field widths.
- Sub-module `memc_pix_cnt`: col/row/blk counters with wrap flags. It is reused by the MEMC datapath for read addressing.

## Test plan
- Reset, then 4096 pixels of frame 1:
  - `fb_addr` sequence 0,1,..,7,64,65,..; pixel 64 → addr 8; pixel 512 → addr 512;
  - `busy` stays 0; no `job_valid`.
- Frame 2 loaded, `job_ready` tied 1, engine returns `res_mv`=8'h1F after 3 cycles:
  - `busy`=1 the cycle after the last pixel;
  - 64 jobs blk 0..63, `job_cur_bank`=1;
  - 64 `mv_valid` with `mv_addr` 0..63;
  - `busy`=0 after the last result.
- `MAX_OUT`=2 with a result delay of 10 cycles: outstanding never exceeds 2; `job_valid` drops while the limit is reached.
- `job_ready` low for 5 cycles on blk 7: `job_blk` holds 7 and `job_valid` stays 1 throughout.
- `pixel_valid` during SEARCH: no `fb_we`, `err`=1. A `res_valid` with outstanding=0 also sets `err`.
- Full sequence of `NUM_FRAMES`=3: exactly 128 `mv_valid`, state ends in DONE with `busy`=1. An `rst` pulse mid-SEARCH returns `busy`=0, `fb_bank`=0, frame count 0.
